// File: rtl/tdc_measure_ctrl.sv
// Single-channel TDC measurement sequencer: arms the FF columns, counts coarse clocks between hits,
// latches the decoder fine bins and presents one interval word. Optional macro: TDC_AUTO_REARM_EN.
module tdc_measure_ctrl #(
  parameter int NUM_BINS    = 256,
  parameter int BITS_DECO   = 8,
  parameter int COARSE_BITS = 12,
  parameter int DECODE_LAT  = 2
) (
  input  logic                             wClk,
  input  logic                             wRst,
  input  logic                             wArm,
  input  logic                             wStartHit,
  input  logic                             wStopHit,
  input  logic [BITS_DECO-1:0]             wStartBin,
  input  logic [BITS_DECO-1:0]             wStopBin,
  output logic                             wCaptureEn,
  output logic                             wBusy,
  output logic                             wValid,
  input  logic                             wReady,
  output logic [COARSE_BITS+BITS_DECO:0]   wTime,
  output logic [COARSE_BITS-1:0]           wCoarse,
  output logic                             wTimeout,
  output logic                             wErr,
  output logic [2:0]                       wDbgState
);

  localparam int TW = COARSE_BITS + BITS_DECO + 1;
  localparam int SW = TW + 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ARMED  = 3'd1,
    S_RUN    = 3'd2,
    S_SETTLE = 3'd3,
    S_OUT    = 3'd4
  } state_t;

  state_t                  r_state;
  state_t                  w_state_n;

  logic [COARSE_BITS-1:0]  r_cnt;
  logic [COARSE_BITS-1:0]  w_k;
  logic [COARSE_BITS-1:0]  r_coarse_lat;
  logic [DECODE_LAT-1:0]   r_start_pipe;
  logic [DECODE_LAT-1:0]   r_stop_pipe;
  logic [BITS_DECO-1:0]    r_start_bin;
  logic [BITS_DECO-1:0]    r_stop_bin;
  logic                    r_start_ok;
  logic                    r_stop_ok;
  logic [TW-1:0]           r_time;
  logic [COARSE_BITS-1:0]  r_coarse_out;
  logic                    r_timeout;
  logic                    r_err;

  logic                    w_start_acc;
  logic                    w_stop_acc;
  logic                    w_timeout_hit;
  logic                    w_compute;
  logic                    w_handshake;
  logic                    w_clear;
  logic                    w_start_due;
  logic                    w_stop_due;
  logic [SW-1:0]           w_diff;
  logic                    w_neg;
  logic                    w_bin_zero;

  // w_k is the number of cycles since the accepted start pulse, valid while in RUN.
  assign w_k         = r_cnt + COARSE_BITS'(1);
  assign w_start_due = r_start_pipe[DECODE_LAT-1];
  assign w_stop_due  = r_stop_pipe[DECODE_LAT-1];

  assign w_diff     = SW'(r_coarse_lat) * SW'(NUM_BINS) + SW'(r_start_bin) - SW'(r_stop_bin);
  assign w_neg      = w_diff[SW-1];
  assign w_bin_zero = (r_start_bin == '0) || (r_stop_bin == '0);

  always_ff @(posedge wClk) begin
    if (wRst) r_state <= S_IDLE;
    else      r_state <= w_state_n;
  end

  // Result handshake: the word transfers on a clock edge where wValid && wReady; while wValid is
  // high and wReady low, wTime/wCoarse/wTimeout/wErr hold and wValid stays high.
  always_comb begin
    w_state_n     = r_state;
    w_start_acc   = 1'b0;
    w_stop_acc    = 1'b0;
    w_timeout_hit = 1'b0;
    w_compute     = 1'b0;
    w_handshake   = 1'b0;
    w_clear       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (wArm) begin
          w_clear   = 1'b1;
          w_state_n = S_ARMED;
        end
      end
      S_ARMED: begin
        if (wStartHit) begin
          w_start_acc = 1'b1;
          if (wStopHit) begin
            w_stop_acc = 1'b1;
            w_state_n  = S_SETTLE;
          end else begin
            w_state_n  = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (wStopHit) begin
          w_stop_acc = 1'b1;
          w_state_n  = S_SETTLE;
        end else if (&w_k) begin
          w_timeout_hit = 1'b1;
          w_state_n     = S_OUT;
        end
      end
      S_SETTLE: begin
        if (r_start_ok && r_stop_ok) begin
          w_compute = 1'b1;
          w_state_n = S_OUT;
        end
      end
      S_OUT: begin
        if (wReady) begin
          w_handshake = 1'b1;
`ifdef TDC_AUTO_REARM_EN
          w_clear   = 1'b1;
          w_state_n = S_ARMED;
`else
          w_state_n = S_IDLE;
`endif
        end
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge wClk) begin
    if (wRst) begin
      r_cnt        <= '0;
      r_coarse_lat <= '0;
      r_start_pipe <= '0;
      r_stop_pipe  <= '0;
      r_start_bin  <= '0;
      r_stop_bin   <= '0;
      r_start_ok   <= 1'b0;
      r_stop_ok    <= 1'b0;
      r_time       <= '0;
      r_coarse_out <= '0;
      r_timeout    <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      // Each accepted hit walks its own pipe so the bins are sampled exactly DECODE_LAT later.
      r_start_pipe <= (r_start_pipe << 1) | DECODE_LAT'(w_start_acc);
      r_stop_pipe  <= (r_stop_pipe << 1) | DECODE_LAT'(w_stop_acc);

      if (w_clear) begin
        r_start_ok <= 1'b0;
        r_stop_ok  <= 1'b0;
      end
      if (w_start_due) begin
        r_start_bin <= wStartBin;
        r_start_ok  <= 1'b1;
      end
      if (w_stop_due) begin
        r_stop_bin <= wStopBin;
        r_stop_ok  <= 1'b1;
      end

      if (w_start_acc)         r_cnt <= '0;
      else if (r_state == S_RUN) r_cnt <= w_k;

      if (w_stop_acc) r_coarse_lat <= (r_state == S_ARMED) ? '0 : w_k;

      if (w_compute) begin
        r_time       <= w_neg ? '0 : w_diff[TW-1:0];
        r_coarse_out <= r_coarse_lat;
        r_timeout    <= 1'b0;
        r_err        <= w_neg || w_bin_zero;
      end else if (w_timeout_hit) begin
        r_time       <= '1;
        r_coarse_out <= '1;
        r_timeout    <= 1'b1;
        r_err        <= 1'b0;
      end else if (w_handshake) begin
        r_timeout    <= 1'b0;
        r_err        <= 1'b0;
      end
    end
  end

  assign wCaptureEn = (r_state == S_ARMED) || (r_state == S_RUN);
  assign wBusy      = (r_state != S_IDLE);
  assign wValid     = (r_state == S_OUT);
  assign wTime      = r_time;
  assign wCoarse    = r_coarse_out;
  assign wTimeout   = r_timeout;
  assign wErr       = r_err;
  assign wDbgState  = r_state;

  a_stall_hold: assert property (@(posedge wClk) disable iff (wRst)
    (wValid && !wReady) |=> (wValid && $stable(wTime) && $stable(wCoarse)
                             && $stable(wTimeout) && $stable(wErr)));

  a_flags_excl: assert property (@(posedge wClk) disable iff (wRst) !(wTimeout && wErr));

endmodule

// File: doc/tdc_measure_ctrl.md
Name: tdc_measure_ctrl

Overview:
Single-channel sequencer for the tapped-delay-line TDC.
- Arms the start and stop FF columns and runs a coarse clock counter between the start and stop hits.
- Latches the fine bins from the start and stop decoders once their pipelines settle.
- Emits a combined interval word on a valid/ready handshake.
- Sits between the start/stop decode blocks and the readout FIFO/UART path.

Parameters:
NUM_BINS, 256, delay-line bins per clock period; fine-to-coarse scale factor
BITS_DECO, 8, width of decoder bin outputs
COARSE_BITS, 12, coarse counter width
DECODE_LAT, 2, cycles from a hit pulse to a valid decoder bin output (≥1)

Ports:
wClk  in  1  system clock; all logic on the rising edge
wRst  in  1  synchronous, active-high reset
wArm  in  1  one-cycle request to start a measurement
wStartHit  in  1  one-cycle pulse: start column captured an edge
wStopHit  in  1  one-cycle pulse: stop column captured an edge
wStartBin  in  BITS_DECO  start decoder output
wStopBin  in  BITS_DECO  stop decoder output
wCaptureEn  out  1  enables FF-column capture
wBusy  out  1  high in any state except IDLE
wValid  out  1  result valid
wReady  in  1  downstream accepts the result
wTime  out  COARSE_BITS+BITS_DECO+1  interval in bins
wCoarse  out  COARSE_BITS  latched coarse count
wTimeout  out  1  result is a timeout
wErr  out  1  result is invalid (bin 0 or negative interval)

Behaviour:
- Reset: state IDLE. wCaptureEn, wBusy, wValid, wTimeout and wErr are 0. wTime and wCoarse are 0. Internal counters and latches are cleared. A reset asserted mid-measurement aborts it with no output.
- States: IDLE, ARMED, RUN, SETTLE, OUT.
- IDLE: wArm=1 goes to ARMED next cycle.
- ARMED:
  - wCaptureEn=1.
  - wStartHit=1 clears the coarse counter and goes to RUN.
  - wStopHit alone is ignored.
  - If wStartHit and wStopHit arrive in the same cycle: coarse=0, go directly to SETTLE.
- RUN:
  - wCaptureEn=1. The counter increments each cycle.
  - On wStopHit arriving k cycles after the start pulse, coarse=k (k≥1); go to SETTLE.
  - A repeated wStartHit is ignored.
  - If k reaches 2^COARSE_BITS-1 with no stop: go to OUT with wTimeout=1, wTime all ones, wCoarse all ones, wErr=0.
- Bin latching:
  - The start bin is latched exactly DECODE_LAT cycles after the accepted start pulse; the stop bin likewise after the accepted stop pulse.
  - A delay pipe per hit tracks this, so a stop that arrives before the start bin has been latched is handled correctly.
- SETTLE: wCaptureEn=0. Wait until both bins are latched, then compute for one cycle and go to OUT.
- Arithmetic: wTime = coarse*NUM_BINS + startBin − stopBin, signed, in COARSE_BITS+BITS_DECO+2 bits.
  - A negative result forces wTime=0 and wErr=1.
  - startBin=0 or stopBin=0 (no edge found) forces wErr=1, and wTime is still the computed value.
- OUT:
  - wValid=1. wTime, wCoarse, wTimeout and wErr stay stable while wValid&&!wReady.
  - On wValid&&wReady, go to IDLE next cycle with wValid=0.
  - Flags clear on leaving OUT.
- wArm outside IDLE is ignored and is not queued.
- Total latency: stop pulse to wValid = DECODE_LAT+2 cycles, when the start bin is already latched.

Optional Feature:
Macro TDC_AUTO_REARM_EN.
- Defined: a completed OUT handshake goes straight to ARMED, and wCaptureEn rises the next cycle with no wArm needed. wArm is still accepted in IDLE, which is then reached only from reset.
- Undefined: OUT goes to IDLE, and every measurement needs a wArm pulse.

Test Plan:
- Arm; start with wStartBin=200; stop 3 cycles later with wStopBin=50; wReady=1 → coarse=3, wTime=3*256+200−50=918, wErr=0, wValid DECODE_LAT+2 cycles after stop.
- Start and stop in the same cycle, bins 100/40 → coarse=0, wTime=60. Then bins 40/100 → wTime=0, wErr=1.
- Arm with start only, COARSE_BITS=4 → after 15 cycles wValid=1, wTimeout=1, wTime all ones.
- Result valid with wReady=0 for 10 cycles, wArm and hit pulses injected meanwhile → outputs frozen, pulses ignored; accepted when wReady=1, then back in IDLE.
- wRst pulsed in RUN → next cycle state IDLE, wCaptureEn=0, and no wValid is ever produced for the aborted measurement.
- TDC_AUTO_REARM_EN defined: two back-to-back measurements with a single wArm → wCaptureEn re-asserts 1 cycle after the first handshake; second result is correct.
